// File: rtl/inst_cache_refill.sv
// Instruction-cache line refill engine.
// Issues one 8-beat AXI4 INCR read per miss and assembles the beats into a
// 256-bit line. Forwards the missed word to fetch the moment it arrives, then
// writes the line and its tag in a single cycle.
module inst_cache_refill #(
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 5,
    parameter int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    // refill request from the fetch stage
    input  logic                   req_valid,
    input  logic [31:0]            req_addr,
    output logic                   req_ready,
    input  logic                   cancel,
    // AXI4 read address channel
    output logic                   arvalid,
    output logic [31:0]            araddr,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    input  logic                   arready,
    // AXI4 read data channel
    input  logic                   rvalid,
    input  logic [31:0]            rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    output logic                   rready,
    // data RAM write port
    output logic                   data_en,
    output logic [31:0]            data_wen,
    output logic [INDEX_WIDTH-1:0] data_index,
    output logic [255:0]           data_wdata,
    // tag/valid array write port
    output logic                   tag_wen,
    output logic [INDEX_WIDTH-1:0] tag_index,
    output logic [TAG_WIDTH:0]     tag_wdata,
    // critical-word forward and completion
    output logic                   fwd_valid,
    output logic [31:0]            fwd_data,
    output logic                   refill_done,
    output logic                   refill_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AR    = 2'd1,
        ST_R     = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [31:2]    addr_q, addr_d;     // byte lane bits are never needed
    logic [2:0]     cnt_q, cnt_d;       // beat counter, also the word slot
    logic           err_q, err_d;       // bus error or bad rlast framing
    logic           cancel_q, cancel_d; // refill abandoned, burst still drained
    logic [255:0]   line_q, line_d;     // word 0 lives in the MSBs

    logic           beat;
    logic           crit_beat;
    logic           do_write;
    logic [1:0]     unused_addr_bits;

    assign unused_addr_bits = req_addr[1:0];

    // The read request shape never changes: 8 beats of 4 bytes, incrementing.
    assign arlen   = 8'd7;
    assign arsize  = 3'd2;
    assign arburst = 2'b01;

    // The line-aligned address is held in addr_q, so it is stable through AR.
    assign araddr  = {addr_q[31:5], 5'b0};

    assign beat      = (state_q == ST_R) && rvalid;
    assign crit_beat = beat && (cnt_q == addr_q[4:2]) && !cancel && !cancel_q;
    assign do_write  = (state_q == ST_WRITE) && !err_q && !cancel_q;

    // State, request latch, flags and line buffer.
    // NOTE: non-blocking assignments here so every flop samples the pre-edge
    // value of its _d input, independent of statement order.
    // NOTE: the line buffer is a plain register, not a RAM, so it takes the
    // reset and the written-line output is all zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            cancel_q <= 1'b0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            cancel_q <= cancel_d;
            line_q   <= line_d;
        end
    end

    // Next-state logic and beat assembly.
    // NOTE: every _d gets its hold value before the case statement, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        cancel_d = cancel_q;
        line_d   = line_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr[31:2];
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    cancel_d = 1'b0;
                    state_d  = ST_AR;
                end
            end
            ST_AR: begin
                if (cancel) begin
                    cancel_d = 1'b1;
                end
                // Once presented the address is never withdrawn, even if cancelled.
                if (arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (cancel) begin
                    cancel_d = 1'b1;
                end
                if (rvalid) begin
                    for (int i = 0; i < 8; i++) begin
                        if (cnt_q == 3'(i)) begin
                            line_d[255-32*i -: 32] = rdata;
                        end
                    end
                    // rlast must appear on exactly the eighth beat.
                    if (rresp != 2'b00 || (rlast != (cnt_q == 3'd7))) begin
                        err_d = 1'b1;
                    end
                    cnt_d = cnt_q + 3'd1;
                    // The line closes on beat 7 whatever rlast says.
                    if (cnt_q == 3'd7) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshakes, forward path and RAM/tag write strobes.
    always_comb begin
        req_ready   = (state_q == ST_IDLE) && !reset;
        arvalid     = (state_q == ST_AR);
        rready      = (state_q == ST_R);

        fwd_valid   = crit_beat;
        fwd_data    = crit_beat ? rdata : 32'h0;

        refill_done = (state_q == ST_WRITE);
        refill_err  = (state_q == ST_WRITE) && err_q;

        data_en     = do_write;
        data_wen    = do_write ? 32'hFFFF_FFFF : 32'h0;
        data_index  = do_write ? addr_q[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH] : '0;
        data_wdata  = line_q;

        tag_wen     = do_write;
        tag_index   = do_write ? addr_q[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH] : '0;
        tag_wdata   = do_write ? {1'b1, addr_q[31:32-TAG_WIDTH]} : '0;
    end

endmodule
